// File: rtl/cond_unit.sv
// Conditional-execution stage: holds NZCV, evaluates the condition field and gates the decoder's write strobes.
// Optional performance counters (ExecCnt/SquashCnt) are built only when COND_PERF_CNT_EN is defined.
module cond_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             Stall,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags
`ifdef COND_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt
`endif
);

    logic [3:0] flags_q;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       base_true;
    logic       commit;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Odd condition codes are the complement of the even code below them.
    always_comb begin
        base_true = 1'b0;
        case (Cond[3:1])
            3'b000:  base_true = flag_z;
            3'b001:  base_true = flag_c;
            3'b010:  base_true = flag_n;
            3'b011:  base_true = flag_v;
            3'b100:  base_true = flag_c & ~flag_z;
            3'b101:  base_true = (flag_n == flag_v);
            3'b110:  base_true = ~flag_z & (flag_n == flag_v);
            default: base_true = 1'b1;
        endcase
    end

    assign CondEx   = base_true ^ Cond[0];
    assign commit   = CondEx & ~Stall;
    assign PCSrc    = PCS  & commit;
    assign RegWrite = RegW & commit;
    assign MemWrite = MemW & commit;
    assign Flags    = flags_q;

    // N,Z and C,V halves load independently, only from committed instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (commit) begin
            if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

`ifdef COND_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ExecCnt   <= '0;
            SquashCnt <= '0;
        end else if (!Stall) begin
            if (CondEx) ExecCnt   <= ExecCnt + 1'b1;
            else        SquashCnt <= SquashCnt + 1'b1;
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: expected strobes/flags are queued at drive time and checked after the edge.
// Counter checks are compiled in only when COND_PERF_CNT_EN is defined (counters then run at CNT_W=4).
module tb_cond_unit;

`ifdef COND_PERF_CNT_EN
    localparam int TB_CNT_W = 4;
`else
    localparam int TB_CNT_W = 32;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, Stall;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;
`ifdef COND_PERF_CNT_EN
    logic [TB_CNT_W-1:0] ExecCnt, SquashCnt;
    logic [TB_CNT_W-1:0] m_exec, m_squash;
`endif

    typedef struct packed {
        logic [3:0] strobes;
        logic [3:0] flags;
    } exp_t;

    exp_t       sb_q[$];
    int         n_compared;
    int         n_mismatched;
    logic [3:0] m_flags;

    cond_unit #(.CNT_W(TB_CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .Stall    (Stall),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags)
`ifdef COND_PERF_CNT_EN
        ,
        .ExecCnt  (ExecCnt),
        .SquashCnt(SquashCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition table written out code by code.
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [3:0] c, input logic [3:0] a,
                                 input logic [1:0] fw, input logic pcs, input logic regw,
                                 input logic memw, input logic stall);
        logic       ce, commit;
        exp_t       e, got;
        logic [3:0] obs;
        @(negedge clk);
        Cond = c; ALUFlags = a; FlagW = fw; PCS = pcs; RegW = regw; MemW = memw; Stall = stall;
        ce     = model_cond(c, m_flags);
        commit = ce && !stall;
        e.strobes = {ce, pcs && commit, regw && commit, memw && commit};
        e.flags   = m_flags;
        if (commit && fw[1]) e.flags[3:2] = a[3:2];
        if (commit && fw[0]) e.flags[1:0] = a[1:0];
        sb_q.push_back(e);
        m_flags = e.flags;
`ifdef COND_PERF_CNT_EN
        if (!stall) begin
            if (ce) m_exec++;
            else    m_squash++;
        end
`endif
        #1;
        obs = {CondEx, PCSrc, RegWrite, MemWrite};
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            checkOutput({tag, "_strobes"}, {28'd0, obs}, {28'd0, got.strobes});
            checkOutput({tag, "_flags"}, {28'd0, Flags}, {28'd0, got.flags});
`ifdef COND_PERF_CNT_EN
            checkOutput({tag, "_exec"}, 32'(ExecCnt), 32'(m_exec));
            checkOutput({tag, "_squash"}, 32'(SquashCnt), 32'(m_squash));
`endif
        end
    endtask

    // Reset asserted between edges with a flag-setting instruction pending; the write must be lost.
    task automatic pulseReset();
        @(negedge clk);
        Cond = 4'hE; ALUFlags = 4'hF; FlagW = 2'b11; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; Stall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_flags_now", {28'd0, Flags}, 32'd0);
`ifdef COND_PERF_CNT_EN
        checkOutput("rst_exec_now", 32'(ExecCnt), 32'd0);
        checkOutput("rst_squash_now", 32'(SquashCnt), 32'd0);
`endif
        Cond = 4'h1; RegW = 1'b1;
        #1;
        checkOutput("rst_ne_regwrite", {31'd0, RegWrite}, 32'd1);
        Cond = 4'h0;
        #1;
        checkOutput("rst_eq_regwrite", {31'd0, RegWrite}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_flags_held", {28'd0, Flags}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        RegW    = 1'b0;
        m_flags = 4'b0000;
`ifdef COND_PERF_CNT_EN
        m_exec   = '0;
        m_squash = '0;
`endif
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        m_flags      = 4'b0000;
`ifdef COND_PERF_CNT_EN
        m_exec   = '0;
        m_squash = '0;
`endif
        rst_n = 1'b0;
        Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; Stall = 1'b0;
        #2;
        checkOutput("por_flags", {28'd0, Flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        pulseReset();

        $display("[TB] split flag write");
        applyStimulus("split_a", 4'hE, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("split_b", 4'hE, 4'b1011, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("split_const", {28'd0, Flags}, 32'h7);

        $display("[TB] squashed setter");
        pulseReset();
        applyStimulus("squash", 4'h0, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("squash_const", {28'd0, Flags}, 32'h0);

        $display("[TB] stall");
        applyStimulus("stall", 4'hE, 4'b1000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus("unstall", 4'hE, 4'b1000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("unstall_const", {28'd0, Flags}, 32'h8);

        $display("[TB] condition sweep");
        for (int f = 0; f < 16; f++) begin
            applyStimulus($sformatf("load_f%0h", f), 4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++)
                applyStimulus($sformatf("sweep_f%0h_c%0h", f, c), 4'(c), 4'(c), 2'b00,
                              1'b1, 1'b1, 1'b1, 1'b0);
        end

        $display("[TB] random mix");
        for (int i = 0; i < 60; i++)
            applyStimulus($sformatf("rand_%0d", i), 4'($urandom), 4'($urandom), 2'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));

`ifdef COND_PERF_CNT_EN
        $display("[TB] counter wrap");
        pulseReset();
        for (int i = 0; i < 17; i++)
            applyStimulus($sformatf("wrap_%0d", i), 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_exec_const", 32'(ExecCnt), 32'd1);
        checkOutput("wrap_squash_const", 32'(SquashCnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
